// File: rtl/clock_alarm_pkg.sv
// Shared definitions for the alarm clock: setting-select codes, BCD field limits
// and the packed-BCD increment used by both alarm fields.
package clock_alarm_pkg;

   typedef enum logic [1:0] {
      SEL_NONE = 2'b00,
      SEL_HOUR = 2'b01,
      SEL_MIN  = 2'b10,
      SEL_RSVD = 2'b11
   } sel_e;

   localparam logic [7:0] HOUR_MAX = 8'h23;
   localparam logic [7:0] MIN_MAX  = 8'h59;

   function automatic logic is_bcd(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   // Anything at or past the limit, or not valid BCD, wraps straight to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] limit);
      logic [7:0] nxt;
      if (!is_bcd(v) || (v >= limit))
         nxt = 8'h00;
      else if (v[3:0] == 4'd9)
         nxt = {v[7:4] + 4'd1, 4'd0};
      else
         nxt = {v[7:4], v[3:0] + 4'd1};
      return nxt;
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// Two-digit packed-BCD up counter wrapping from LIMIT to 00, with a
// synchronous active-low clear that overrides the increment.
module bcd_counter
   import clock_alarm_pkg::*;
#(
   parameter logic [7:0] LIMIT = MIN_MAX
) (
   input  logic       clk,
   input  logic       cr,
   input  logic       inc,
   output logic [7:0] count
);

   always_ff @(posedge clk) begin
      if (!cr)
         count <= 8'h00;
      else if (inc)
         count <= bcd_inc(count, LIMIT);
   end

endmodule

// File: rtl/clock_alarm.sv
// Alarm time storage and compare: rings for the whole matching minute, with the
// beep gated combinationally by en and the 2 Hz tone.
module clock_alarm
   import clock_alarm_pkg::*;
(
   input  logic       clk_1hz,
   input  logic       cr,
   input  logic       clk_2hz,
   input  logic       en,
   input  logic [1:0] alarm_set_select,
   input  logic       set_confirm,
   input  logic [7:0] clock_hour,
   input  logic [7:0] clock_minute,
   output logic [7:0] alarm_hour,
   output logic [7:0] alarm_minute,
   output logic       alarm
);

   sel_e sel;
   logic inc_hour;
   logic inc_min;
   logic match;
   logic ring;

   assign sel      = sel_e'(alarm_set_select);
   assign inc_hour = set_confirm && (sel == SEL_HOUR);
   assign inc_min  = set_confirm && (sel == SEL_MIN);
   assign match    = (clock_hour == alarm_hour) && (clock_minute == alarm_minute);

   bcd_counter #(.LIMIT(HOUR_MAX)) u_hour (
      .clk   (clk_1hz),
      .cr    (cr),
      .inc   (inc_hour),
      .count (alarm_hour)
   );

   // Minute wrap deliberately does not carry into the hour field.
   bcd_counter #(.LIMIT(MIN_MAX)) u_minute (
      .clk   (clk_1hz),
      .cr    (cr),
      .inc   (inc_min),
      .count (alarm_minute)
   );

   always_ff @(posedge clk_1hz) begin
      if (!cr)
         ring <= 1'b0;
      else
         ring <= en && (sel == SEL_NONE) && match;
   end

   assign alarm = ring && en && clk_2hz;

endmodule

// File: tb/tb_clock_alarm.sv
// Self-checking bench for clock_alarm: directed scenarios then randomized
// stimulus against a decimal-arithmetic reference model.
module tb_clock_alarm;

   logic       clk_1hz = 1'b0;
   logic       cr = 1'b0;
   logic       clk_2hz = 1'b0;
   logic       en = 1'b0;
   logic [1:0] alarm_set_select = 2'b00;
   logic       set_confirm = 1'b0;
   logic [7:0] clock_hour = 8'h00;
   logic [7:0] clock_minute = 8'h00;
   logic [7:0] alarm_hour;
   logic [7:0] alarm_minute;
   logic       alarm;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state held as plain decimal numbers.
   int m_hour = 0;
   int m_min  = 0;
   bit m_ring = 1'b0;

   clock_alarm dut (
      .clk_1hz          (clk_1hz),
      .cr               (cr),
      .clk_2hz          (clk_2hz),
      .en               (en),
      .alarm_set_select (alarm_set_select),
      .set_confirm      (set_confirm),
      .clock_hour       (clock_hour),
      .clock_minute     (clock_minute),
      .alarm_hour       (alarm_hour),
      .alarm_minute     (alarm_minute),
      .alarm            (alarm)
   );

   always #5 clk_1hz = ~clk_1hz;

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t;
      logic [3:0] u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Checks alarm under both tone phases with the current en; leaves clk_2hz low.
   task automatic check_alarm(input string tag);
      clk_2hz = 1'b0;
      #1;
      check_val({tag, "_tone0"}, {7'd0, alarm}, 8'h00);
      clk_2hz = 1'b1;
      #1;
      check_val({tag, "_tone1"}, {7'd0, alarm}, {7'd0, m_ring & en});
      clk_2hz = 1'b0;
   endtask

   // Predict from inputs held before the edge, clock once, then compare.
   task automatic tick(input string tag);
      int  nh, nm;
      bit  nr;
      nh = m_hour;
      nm = m_min;
      if (!cr) begin
         nh = 0; nm = 0; nr = 1'b0;
      end else begin
         nr = en && (alarm_set_select == 2'b00) &&
              (clock_hour == to_bcd(m_hour)) && (clock_minute == to_bcd(m_min));
         if (set_confirm && alarm_set_select == 2'b10) nm = (m_min + 1) % 60;
         if (set_confirm && alarm_set_select == 2'b01) nh = (m_hour + 1) % 24;
      end
      @(posedge clk_1hz);
      #1;
      m_hour = nh;
      m_min  = nm;
      m_ring = nr;
      check_val({tag, "_hour"}, alarm_hour, to_bcd(m_hour));
      check_val({tag, "_min"}, alarm_minute, to_bcd(m_min));
      check_alarm(tag);
   endtask

   initial begin
      // Reset
      cr = 1'b0;
      tick("reset");
      check_val("reset_hour_00", alarm_hour, 8'h00);
      check_val("reset_min_00", alarm_minute, 8'h00);
      cr = 1'b1;

      // Minute set for 7 edges, then hold
      alarm_set_select = 2'b10;
      set_confirm = 1'b1;
      repeat (7) tick("min_set");
      check_val("min_set_07", alarm_minute, 8'h07);
      check_val("min_set_hour00", alarm_hour, 8'h00);
      set_confirm = 1'b0;
      repeat (3) tick("min_hold");
      check_val("min_hold_07", alarm_minute, 8'h07);

      // Match at 00:07
      alarm_set_select = 2'b00;
      en = 1'b1;
      clock_hour = 8'h00;
      clock_minute = 8'h07;
      tick("match_on");
      clk_2hz = 1'b1;
      #1;
      check_val("match_beep", {7'd0, alarm}, 8'h01);
      clk_2hz = 1'b0;
      clock_minute = 8'h08;
      tick("match_off");
      check_val("match_off_silent", {7'd0, alarm}, 8'h00);

      // Gating by en, then by select
      clock_minute = 8'h07;
      tick("gate_ring");
      en = 1'b0;
      clk_2hz = 1'b1;
      #1;
      check_val("gate_en_immediate", {7'd0, alarm}, 8'h00);
      clk_2hz = 1'b0;
      en = 1'b1;
      alarm_set_select = 2'b10;
      tick("gate_sel");
      alarm_set_select = 2'b00;

      // Reset while ringing
      tick("ring_again");
      cr = 1'b0;
      tick("ring_reset");
      check_val("ring_reset_min", alarm_minute, 8'h00);
      cr = 1'b1;

      // Minute wrap with hour preset to 05
      alarm_set_select = 2'b01;
      set_confirm = 1'b1;
      repeat (5) tick("hour_pre");
      alarm_set_select = 2'b10;
      repeat (58) tick("min_pre");
      check_val("min_pre_58", alarm_minute, 8'h58);
      tick("wrap_m1");
      check_val("wrap_59", alarm_minute, 8'h59);
      tick("wrap_m2");
      check_val("wrap_00", alarm_minute, 8'h00);
      check_val("wrap_no_carry", alarm_hour, 8'h05);
      tick("wrap_m3");
      check_val("wrap_01", alarm_minute, 8'h01);

      // Hour wrap from 22
      alarm_set_select = 2'b01;
      repeat (17) tick("hour_pre2");
      check_val("hour_pre_22", alarm_hour, 8'h22);
      tick("wrap_h1");
      check_val("wrap_23", alarm_hour, 8'h23);
      tick("wrap_h2");
      check_val("wrap_h00", alarm_hour, 8'h00);
      set_confirm = 1'b0;

      // Randomized traffic, biased toward matching the stored time
      for (int i = 0; i < 3000; i++) begin
         cr               = ($urandom_range(0, 39) != 0);
         en               = ($urandom_range(0, 3) != 0);
         alarm_set_select = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) alarm_set_select = 2'b00;
         set_confirm      = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 1) == 1) begin
            clock_hour   = to_bcd(m_hour);
            clock_minute = to_bcd(m_min);
         end else begin
            clock_hour   = to_bcd($urandom_range(0, 23));
            clock_minute = to_bcd($urandom_range(0, 59));
         end
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clock_alarm.md
CLOCK_ALARM -- requirements
Module: clock_alarm

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk_1hz  in  1  sole clock; all state changes on its rising edge.
REQ-003 cr  in  1  synchronous active-low clear, sampled on the rising edge of clk_1hz.
REQ-004 clk_2hz  in  1  2 Hz square wave.
- Used only combinationally to gate the alarm tone.
- Never used as a clock.
REQ-005 en  in  1  alarm enable; 1 = alarm may ring.
REQ-006 alarm_set_select  in  2  setting target: 00 none, 01 hour, 10 minute, 11 reserved (no action).
REQ-007 set_confirm  in  1  level-sensitive increment request for the selected field.
REQ-008 clock_hour  in  8  current time hour, packed BCD 00-23.
REQ-009 clock_minute  in  8  current time minute, packed BCD 00-59.
REQ-010 alarm_hour  out  8  stored alarm hour, packed BCD.
REQ-011 alarm_minute  out  8  stored alarm minute, packed BCD.
REQ-012 alarm  out  1  beeping alarm output.

Function
REQ-013 When set_confirm=1 and select=10, alarm_minute SHALL increment by 1 in BCD on every rising edge while the condition holds.
- 09 goes to 10.
- 59 wraps to 00, with no carry into alarm_hour.
REQ-014 When set_confirm=1 and select=01, alarm_hour SHALL increment by 1 in BCD on every rising edge.
- 09 goes to 10; 19 goes to 20.
- 23 wraps to 00.
REQ-015 With select=00 or 11, or set_confirm=0, alarm_hour and alarm_minute SHALL hold.
REQ-016 Setting SHALL work regardless of en.
REQ-017 An internal ring register SHALL be set on the rising edge where all of these hold:
- en=1
- select=00
- clock_hour==alarm_hour and clock_minute==alarm_minute
Otherwise it SHALL clear on that edge, so ringing lasts the whole matching minute.
REQ-018 alarm SHALL equal ring AND en AND clk_2hz, combinationally.
- Latency from a match to the first beep is one clk_1hz edge.
- Clearing en silences alarm immediately.
REQ-019 If a setting change makes the stored time stop matching, ring SHALL clear on the next edge.
REQ-020 The compare SHALL be a plain 8-bit equality; non-BCD clock inputs are compared as-is with no error handling.
REQ-021 If the stored fields hold a non-BCD value, the next increment SHALL wrap them to 00.

Reset
REQ-022 When cr=0 at a rising edge, the block SHALL clear alarm_hour=00, alarm_minute=00 and ring=0; alarm is 0 from the next edge on.
REQ-023 Reset SHALL take priority over setting and matching on the same edge, including mid-increment.

Structure
REQ-024 A shared package SHALL hold:
- select codes SEL_NONE, SEL_HOUR, SEL_MIN, SEL_RSVD
- BCD limits HOUR_MAX=8'h23 and MIN_MAX=8'h59
REQ-025 A single sub-module, bcd_counter, SHALL be used, instantiated twice (hour, minute):
- parameterized by its modulus limit
- inputs: clock, reset, increment enable
- output: 8-bit packed BCD

Verification
REQ-026 Reset: cr=0 for one edge -> alarm_hour=00, alarm_minute=00, alarm=0.
REQ-027 Minute set: select=10, set_confirm=1 for 7 edges -> alarm_minute=07, alarm_hour=00; further edges hold after set_confirm=0.
REQ-028 Wrap: minute preset 58, 3 increments -> 59, 00, 01 with hour unchanged; hour preset 22, 2 increments -> 23, 00.
REQ-029 Match: alarm 00:07, en=1, select=00, clock 00:07 -> ring set after one edge, alarm follows clk_2hz; clock 00:08 -> alarm 0 after next edge.
REQ-030 Gating, with a match active:
- en=0 -> alarm=0 immediately.
- select=10 held -> ring cleared on the next edge.
REQ-031 Reset during ringing: cr=0 -> ring=0 and alarm=0 after the edge; alarm returns to 00:00.
